mult_div_unit: RTL and testbench

- Multicycle signed multiply/divide unit for MULT and DIV, driven directly by the main control FSM.
- Control pulses `start` with an op select; the unit iterates one bit per clock and writes the HI/LO registers.
- It then pulses `done` so control can leave its wait state and let MFHI/MFLO read HI/LO through the register-write mux.
- Operands come from the A/B registers.

---
 rtl/mult_div_pkg.sv | 16 +
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit_div_step.sv | 25 ++
 rtl/mult_div_unit.sv | 140 ++++++++++++++
 tb/tb_mult_div_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared state enum, op encodings and default width
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    FINISH
  } state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - control-side handshake and HI/LO result bundle
interface mult_div_unit_if
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/mult_div_unit_div_step.sv
// rtl/mult_div_unit_div_step.sv - one restoring shift/trial-subtract step on magnitudes
module mult_div_unit_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits
  // and the top bit of the trial difference is its sign.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, dvsr};
    quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed Booth multiply / restoring divide writing HI/LO
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH + 1;

  state_t           state_q, state_d;
  logic [PW-1:0]    prod_q, prod_next;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic             quo_neg_q, rem_neg_q;
  logic [CW-1:0]    count_q;
  logic             busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             last_iter;
  logic             start_div_zero;
  logic [WIDTH:0]   upper_ext, mcand_ext, booth_sum;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign last_iter      = (count_q == CW'(WIDTH - 1));
  assign start_div_zero = bus.start && (bus.op == OP_DIV) && (bus.b == '0);

  mult_div_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvsr     (dvsr_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Booth step: the add/sub is one bit wider so a most-negative multiplicand
  // cannot overflow before the arithmetic shift folds the sign back in.
  always_comb begin
    upper_ext = {prod_q[PW-1], prod_q[PW-1:WIDTH+1]};
    mcand_ext = {mcand_q[WIDTH-1], mcand_q};
    case (prod_q[1:0])
      2'b01:   booth_sum = upper_ext + mcand_ext;
      2'b10:   booth_sum = upper_ext - mcand_ext;
      default: booth_sum = upper_ext;
    endcase
    prod_next = {booth_sum, prod_q[WIDTH:1]};
  end

  // Next-state logic; FINISH always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MULT)   state_d = MULT;
          else if (start_div_zero) state_d = FINISH;
          else                     state_d = DIV;
        end
      end
      MULT, DIV: if (last_iter) state_d = FINISH;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath: operand capture, iteration, and the single HI/LO write on FINISH entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q     <= '0;
      mcand_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      busy_q     <= (state_d == MULT) || (state_d == DIV);
      done_q     <= (state_d == FINISH);
      div_zero_q <= (state_q == IDLE) && start_div_zero;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            count_q   <= '0;
            mcand_q   <= bus.a;
            prod_q    <= {{WIDTH{1'b0}}, bus.b, 1'b0};
            rem_q     <= '0;
            quo_q     <= mag(bus.a);
            dvsr_q    <= mag(bus.b);
            quo_neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            rem_neg_q <= bus.a[WIDTH-1];
          end
        end
        MULT: begin
          prod_q  <= prod_next;
          count_q <= count_q + CW'(1);
          if (last_iter) begin
            hi_q <= prod_next[PW-1:WIDTH+1];
            lo_q <= prod_next[WIDTH:1];
          end
        end
        DIV: begin
          rem_q   <= rem_next;
          quo_q   <= quo_next;
          count_q <= count_q + CW'(1);
          if (last_iter) begin
            hi_q <= rem_neg_q ? -rem_next : rem_next;
            lo_q <= quo_neg_q ? -quo_next : quo_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  logic [W-1:0] model_hi, model_lo;
  int n_vec = 0;
  int n_err = 0;
  int done_count = 0;

  // Count every done pulse seen by the bench.
  always @(negedge clk) if (bus.done === 1'b1) done_count++;

  // Reference model: pushes expected HI/LO/div_zero/latency for one operation.
  task automatic predict(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz  = 1'b0;
    e.lat = W + 1;
    if (op == OP_MULT) begin
      p = sa * sb;
      model_hi = p[63:32];
      model_lo = p[31:0];
    end else if (b == '0) begin
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      model_hi = r[31:0];
      model_lo = q[31:0];
    end
    e.hi = model_hi;
    e.lo = model_lo;
    exp_q.push_back(e);
  endtask

  // Drive one start and wait (bounded) for done; operands are scrambled after capture.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cycles, output int busy_cycles,
                        output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    cycles = 1;
    busy_cycles = 0;
    while (bus.done !== 1'b1 && cycles < 100) begin
      if (bus.busy === 1'b1) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    hi = bus.hi;
    lo = bus.lo;
    dz = bus.div_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.op = 1'b0; bus.a = '1; bus.b = '1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_hi = '0; model_lo = '0;
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_vec++; if (bus.div_zero !== 1'b0) begin n_err++; $display("FAIL reset_div_zero: got %b expected 0", bus.div_zero); end
    n_vec++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h expected 00000000", bus.hi); end
    n_vec++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h expected 00000000", bus.lo); end
  endtask

  task automatic test_mult();
    logic [W-1:0] av[6] = '{32'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678};
    logic [W-1:0] bv[6] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hDEAD_BEEF, 32'hFEDC_BA98};
    int cyc, bcyc; logic [W-1:0] hi, lo; logic dz; exp_t e;
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] a, b;
      a = (i < 6) ? av[i] : $urandom;
      b = (i < 6) ? bv[i] : $urandom;
      predict(OP_MULT, a, b);
      run_op(OP_MULT, a, b, cyc, bcyc, hi, lo, dz);
      e = exp_q.pop_front();
      n_vec++; if (hi !== e.hi) begin n_err++; $display("FAIL mult_hi[%0d]: got %h expected %h", i, hi, e.hi); end
      n_vec++; if (lo !== e.lo) begin n_err++; $display("FAIL mult_lo[%0d]: got %h expected %h", i, lo, e.lo); end
      n_vec++; if (dz !== e.dz) begin n_err++; $display("FAIL mult_div_zero[%0d]: got %b expected %b", i, dz, e.dz); end
      n_vec++; if (cyc != e.lat) begin n_err++; $display("FAIL mult_latency[%0d]: got %0d expected %0d", i, cyc, e.lat); end
      n_vec++; if (bcyc != W) begin n_err++; $display("FAIL mult_busy_cycles[%0d]: got %0d expected %0d", i, bcyc, W); end
      if (i == 0) begin
        n_vec++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_err++; $display("FAIL mult_7x-3: got %h%h expected ffffffffffffffeb", hi, lo); end
      end
      if (i == 1) begin
        n_vec++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin n_err++; $display("FAIL mult_minxmin: got %h%h expected 4000000000000000", hi, lo); end
      end
    end
  endtask

  task automatic test_div();
    logic [W-1:0] av[5] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd5, 32'hFFFF_FF9C};
    logic [W-1:0] bv[5] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFF9};
    int cyc, bcyc; logic [W-1:0] hi, lo; logic dz; exp_t e;
    for (int i = 0; i < 9; i++) begin
      logic [W-1:0] a, b;
      a = (i < 5) ? av[i] : $urandom;
      b = (i < 5) ? bv[i] : ($urandom | 32'h1) >> $urandom_range(0, 31);
      predict(OP_DIV, a, b);
      run_op(OP_DIV, a, b, cyc, bcyc, hi, lo, dz);
      e = exp_q.pop_front();
      n_vec++; if (hi !== e.hi) begin n_err++; $display("FAIL div_hi[%0d]: got %h expected %h", i, hi, e.hi); end
      n_vec++; if (lo !== e.lo) begin n_err++; $display("FAIL div_lo[%0d]: got %h expected %h", i, lo, e.lo); end
      n_vec++; if (dz !== e.dz) begin n_err++; $display("FAIL div_div_zero[%0d]: got %b expected %b", i, dz, e.dz); end
      n_vec++; if (cyc != e.lat) begin n_err++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, cyc, e.lat); end
      if (i == 0) begin
        n_vec++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_-7/2: got %h/%h expected ffffffff/fffffffd", hi, lo); end
      end
      if (i == 1) begin
        n_vec++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL div_100/7: got %h/%h expected 00000002/0000000e", hi, lo); end
      end
      if (i == 2) begin
        n_vec++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin n_err++; $display("FAIL div_min/-1: got %h/%h expected 00000000/80000000", hi, lo); end
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc, bcyc; logic [W-1:0] hi, lo; logic dz; exp_t e;
    predict(OP_MULT, 32'h6666_6666, 32'h2AAA_AAAB);
    run_op(OP_MULT, 32'h6666_6666, 32'h2AAA_AAAB, cyc, bcyc, hi, lo, dz);
    e = exp_q.pop_front();
    n_vec++; if ({hi, lo} !== 64'h1111_1111_2222_2222) begin n_err++; $display("FAIL dz_preload: got %h/%h expected 11111111/22222222", hi, lo); end
    predict(OP_DIV, 32'd1234, 32'd0);
    run_op(OP_DIV, 32'd1234, 32'd0, cyc, bcyc, hi, lo, dz);
    e = exp_q.pop_front();
    n_vec++; if (cyc != e.lat) begin n_err++; $display("FAIL dz_latency: got %0d expected %0d", cyc, e.lat); end
    n_vec++; if (dz !== e.dz) begin n_err++; $display("FAIL dz_flag: got %b expected %b", dz, e.dz); end
    n_vec++; if (hi !== e.hi || hi !== 32'h1111_1111) begin n_err++; $display("FAIL dz_hi_kept: got %h expected %h", hi, e.hi); end
    n_vec++; if (lo !== e.lo || lo !== 32'h2222_2222) begin n_err++; $display("FAIL dz_lo_kept: got %h expected %h", lo, e.lo); end
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL dz_done_pulse: got %b expected 0", bus.done); end
    n_vec++; if (bus.div_zero !== 1'b0) begin n_err++; $display("FAIL dz_flag_pulse: got %b expected 0", bus.div_zero); end
  endtask

  task automatic test_start_ignored();
    int cyc, d0; exp_t e;
    predict(OP_MULT, 32'd5, 32'd6);
    d0 = done_count;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd5; bus.b = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (cyc == 10) begin bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd100; bus.b = 32'd0; end
      else bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    e = exp_q.pop_front();
    n_vec++; if (bus.lo !== e.lo || bus.lo !== 32'd30) begin n_err++; $display("FAIL ign_lo: got %h expected %h", bus.lo, e.lo); end
    n_vec++; if (bus.hi !== e.hi) begin n_err++; $display("FAIL ign_hi: got %h expected %h", bus.hi, e.hi); end
    n_vec++; if (cyc != e.lat) begin n_err++; $display("FAIL ign_latency: got %0d expected %0d", cyc, e.lat); end
    repeat (40) @(negedge clk);
    #1;
    n_vec++; if (done_count - d0 != 1) begin n_err++; $display("FAIL ign_done_count: got %0d expected 1", done_count - d0); end
  endtask

  task automatic test_reset_mid();
    int cyc, bcyc, d0; logic [W-1:0] hi, lo; logic dz; exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'h0001_2345; bus.b = 32'h0000_0777;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_hi = '0; model_lo = '0;
    #1;
    d0 = done_count;
    n_vec++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL rst_state: got %0d expected %0d", dut.state_q, IDLE); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", bus.done); end
    n_vec++; if ({bus.hi, bus.lo} !== 64'h0) begin n_err++; $display("FAIL rst_hilo: got %h/%h expected 0/0", bus.hi, bus.lo); end
    repeat (40) @(negedge clk);
    #1;
    n_vec++; if (done_count != d0) begin n_err++; $display("FAIL rst_no_done: got %0d expected 0", done_count - d0); end
    predict(OP_MULT, 32'd3, 32'd4);
    run_op(OP_MULT, 32'd3, 32'd4, cyc, bcyc, hi, lo, dz);
    e = exp_q.pop_front();
    n_vec++; if (lo !== e.lo || lo !== 32'd12) begin n_err++; $display("FAIL rst_fresh_lo: got %h expected %h", lo, e.lo); end
    n_vec++; if (hi !== e.hi) begin n_err++; $display("FAIL rst_fresh_hi: got %h expected %h", hi, e.hi); end
    n_vec++; if (cyc != e.lat) begin n_err++; $display("FAIL rst_fresh_latency: got %0d expected %0d", cyc, e.lat); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
